// File: rtl/prescaled_event_counter_pkg.sv
// Shared constants and helpers for the prescaled event counter.
// Direction and mode encodings match the up_dn and sat input levels.
package prescaled_event_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold the values 0..value-1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned top;
    res = 0;
    top = value - 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((top >> i) != 0) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last count as a
// one-cycle clock-enable tick.
module tick_gen
  import prescaled_event_counter_pkg::*;
#(
  parameter int unsigned DIV = 50000,
  parameter int unsigned PW  = clog2(DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_o
);

  localparam logic [PW-1:0] LastVal = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          at_last;

  assign at_last = (presc_q == LastVal);

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = at_last ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = en & at_last;

endmodule

// File: rtl/prescaled_event_counter.sv
// Up/down event counter advanced by an internal prescaler tick, with modulus,
// wrap/saturate, load, clear, terminal-count pulse, sticky overflow and display snapshot.
module prescaled_event_counter
  import prescaled_event_counter_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned DIV = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_dn,
  input  logic         sat,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] modulus,
  input  logic         hold,
  input  logic         ovf_clr,
  output logic         tick_o,
  output logic [W-1:0] count,
  output logic [W-1:0] count_disp,
  output logic         tc,
  output logic         ovf_sticky
);

  localparam int unsigned PW = clog2(DIV);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] disp_q, disp_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         boundary;
  logic         tick;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .clr    (clr),
    .tick_o (tick)
  );

  // Priority: clr > load > tick step > hold value
  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > modulus) ? modulus : load_val;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (count_q >= modulus) begin
          boundary = 1'b1;
          count_d  = (sat == MODE_SAT) ? modulus : '0;
        end else begin
          count_d = count_q + W'(1);
        end
      end else begin
        // Above a lowered modulus a down step only clamps; not a boundary
        if (count_q > modulus) begin
          count_d = modulus;
        end else if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = (sat == MODE_SAT) ? '0 : modulus;
        end else begin
          count_d = count_q - W'(1);
        end
      end
    end
  end

  always_comb begin
    tc_d   = boundary;
    ovf_d  = boundary | (ovf_q & ~ovf_clr);
    disp_d = hold ? disp_q : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      disp_q  <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      disp_q  <= disp_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tick_o     = tick;
  assign count      = count_q;
  assign count_disp = disp_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_prescaled_event_counter.sv
// Bench for prescaled_event_counter: directed vector table, hand-written corner
// sequences and randomized stimulus against a cycle-level reference model.
module tb_prescaled_event_counter;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset, en, up_dn, sat, clr, load, hold, ovf_clr;
  logic [W-1:0] load_val, modulus;
  logic         tick_o, tc, ovf_sticky;
  logic [W-1:0] count, count_disp;

  prescaled_event_counter #(
    .W   (W),
    .DIV (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_dn      (up_dn),
    .sat        (sat),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .modulus    (modulus),
    .hold       (hold),
    .ovf_clr    (ovf_clr),
    .tick_o     (tick_o),
    .count      (count),
    .count_disp (count_disp),
    .tc         (tc),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: prescaler phase, counter value and flags as plain integers
  int m_presc = 0;
  int m_count = 0;
  int m_disp  = 0;
  int m_tc    = 0;
  int m_ovf   = 0;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void model_update();
    int mod;
    int lv;
    int nxt;
    int bnd;
    int tk;
    mod = int'(modulus);
    lv  = int'(load_val);
    tk  = (en && m_presc == DIV - 1) ? 1 : 0;
    nxt = m_count;
    bnd = 0;
    if (reset) begin
      m_presc = 0; m_count = 0; m_disp = 0; m_tc = 0; m_ovf = 0;
      return;
    end
    if (clr) begin
      nxt = 0;
    end else if (load) begin
      nxt = (lv < mod) ? lv : mod;
    end else if (tk == 1) begin
      if (up_dn) begin
        if (m_count < mod) nxt = m_count + 1;
        else begin bnd = 1; nxt = sat ? mod : 0; end
      end else begin
        if (m_count > mod) nxt = mod;
        else if (m_count == 0) begin bnd = 1; nxt = sat ? 0 : mod; end
        else nxt = m_count - 1;
      end
    end
    m_disp  = hold ? m_disp : m_count;
    m_presc = clr ? 0 : (en ? (m_presc + 1) % DIV : m_presc);
    m_tc    = bnd;
    m_ovf   = (bnd == 1) ? 1 : (ovf_clr ? 0 : m_ovf);
    m_count = nxt;
  endfunction

  function automatic void compare_model();
    check("model_tick_o", int'(tick_o), (en && m_presc == DIV - 1) ? 1 : 0);
    check("model_count", int'(count), m_count);
    check("model_count_disp", int'(count_disp), m_disp);
    check("model_tc", int'(tc), m_tc);
    check("model_ovf_sticky", int'(ovf_sticky), m_ovf);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic         en, up, sat, clr, load;
    logic [W-1:0] lv, mod;
    logic         hold, oclr;
    int           n;
    int           e_tick, e_cnt, e_tc, e_ovf;
  } vec_t;

  function automatic vec_t mk(int v_en, int v_up, int v_sat, int v_clr, int v_load, int v_lv,
                              int v_mod, int v_oclr, int v_n, int x_tick, int x_cnt, int x_tc,
                              int x_ovf);
    vec_t v;
    v.en = 1'(v_en); v.up = 1'(v_up); v.sat = 1'(v_sat); v.clr = 1'(v_clr);
    v.load = 1'(v_load); v.lv = W'(v_lv); v.mod = W'(v_mod); v.hold = 1'b0;
    v.oclr = 1'(v_oclr); v.n = v_n;
    v.e_tick = x_tick; v.e_cnt = x_cnt; v.e_tc = x_tc; v.e_ovf = x_ovf;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    int k;
    // Directed rows: en up sat clr load lv mod oclr cycles | tick count tc ovf
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 5, 0, 3,  1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 5, 0, 1,  0, 1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 5, 0, 19, 1, 5, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 5, 0, 1,  0, 0, 1, 1);
    vecs[4]  = mk(1, 1, 0, 0, 0, 0, 5, 0, 1,  0, 0, 0, 1);
    vecs[5]  = mk(1, 1, 0, 1, 0, 0, 5, 0, 1,  0, 0, 0, 1);
    vecs[6]  = mk(1, 1, 0, 0, 0, 0, 5, 1, 1,  0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 0, 0, 0, 5, 0, 19, 0, 5, 0, 0);
    vecs[8]  = mk(1, 1, 1, 0, 0, 0, 5, 0, 4,  0, 5, 1, 1);
    vecs[9]  = mk(1, 1, 1, 0, 0, 0, 5, 0, 4,  0, 5, 1, 1);
    vecs[10] = mk(1, 1, 1, 0, 0, 0, 5, 1, 1,  0, 5, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 1, 9, 3, 0, 1,  0, 3, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 3, 0, 2,  0, 2, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 3, 0, 4,  0, 1, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 3, 0, 4,  0, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, 3, 0, 4,  0, 3, 1, 1);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 3, 0, 3,  1, 3, 0, 1);
    vecs[17] = mk(1, 0, 0, 0, 1, 2, 3, 0, 1,  0, 2, 0, 1);
    vecs[18] = mk(1, 1, 0, 0, 0, 0, 3, 0, 4,  0, 3, 0, 1);

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; sat = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = '0; modulus = '0; hold = 1'b0; ovf_clr = 1'b0;

    cycle();
    check("reset_count", int'(count), 0);
    check("reset_flags", int'({tick_o, tc, ovf_sticky}), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      en = vecs[i].en; up_dn = vecs[i].up; sat = vecs[i].sat; clr = vecs[i].clr;
      load = vecs[i].load; load_val = vecs[i].lv; modulus = vecs[i].mod;
      hold = vecs[i].hold; ovf_clr = vecs[i].oclr;
      repeat (vecs[i].n) cycle();
      check($sformatf("row%0d_tick_o", i), int'(tick_o), vecs[i].e_tick);
      check($sformatf("row%0d_count", i), int'(count), vecs[i].e_cnt);
      check($sformatf("row%0d_tc", i), int'(tc), vecs[i].e_tc);
      check($sformatf("row%0d_ovf", i), int'(ovf_sticky), vecs[i].e_ovf);
    end
    clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;

    // Hold freezes the snapshot while counting continues
    hold = 1'b1; modulus = 8'd5; up_dn = 1'b1; sat = 1'b0;
    repeat (8) cycle();
    check("hold_disp_frozen", int'(count_disp), 2);
    check("hold_count_runs", int'(count), 5);
    hold = 1'b0;
    cycle();
    check("hold_release_disp", int'(count_disp), 5);

    // clr mid-period restarts the prescaler
    cycle();
    clr = 1'b1;
    cycle();
    check("clr_count", int'(count), 0);
    clr = 1'b0;
    k = 0;
    while (!tick_o && k < 2 * DIV) begin
      cycle();
      k++;
    end
    check("clr_to_tick_cycles", k, DIV - 1);

    // Boundary and ovf_clr in the same cycle: set wins; modulus 0 pins count at 0
    modulus = '0; ovf_clr = 1'b1; up_dn = 1'b1;
    cycle();
    check("set_wins_ovf", int'(ovf_sticky), 1);
    check("mod0_tc", int'(tc), 1);
    check("mod0_count", int'(count), 0);
    cycle();
    check("ovf_clr_clears", int'(ovf_sticky), 0);
    ovf_clr = 1'b0;

    // Reset mid-count
    modulus = 8'd5;
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    check("midreset_count", int'(count), 0);
    check("midreset_disp", int'(count_disp), 0);
    check("midreset_flags", int'({tick_o, tc, ovf_sticky}), 0);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 9) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      sat      = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0)
        modulus = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      hold     = ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
